data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Word-organised data memory with a multicycle request/ready handshake and byte/halfword lane handling. It sits directly upstream of the memory data register. The controller FSM issues reads and stores; load data is aligned and extended, then presented on rdata for the memory data register to capture. Read latency is configurable so the control FSM can be exercised against slow memory.

Parameters:
ADDR_W, 8, word-address bits; the array depth is 2**ADDR_W 32-bit words.
READ_LAT, 2, wait-state cycles on reads; legal range 1..7.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
mem_read  in  1  read request, level-sensitive, sampled only in IDLE.
mem_write  in  1  write request, level-sensitive, sampled only in IDLE.
addr  in  32  byte address; bits [ADDR_W+1:2] select the word; higher bits are ignored (wrap).
size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
sign_ext  in  1  1 = sign-extend byte/half loads, 0 = zero-extend.
wdata  in  32  store data, right-justified for byte/half.
rdata  out  32  aligned, extended load data; feeds the memory data register.
ready  out  1  one-cycle pulse marking completion of the accepted operation.
busy  out  1  high in every state except IDLE.
misalign  out  1  valid with ready; 1 = operation rejected for misalignment.

Behaviour:
- Reset (async assert, any state):
  - State goes to IDLE; rdata=0, ready=0, busy=0, misalign=0, wait counter=0.
  - Memory array is not reset.
- Storage layout:
  - Little-endian: byte lane n = addr[1:0] maps to bits [8n+7:8n].
  - Half lane addr[1] maps to bits [16*addr[1]+15 : 16*addr[1]].
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE:
  - On an edge with mem_read or mem_write high, the request is accepted.
  - addr, size, sign_ext and wdata are latched at acceptance; later input changes have no effect.
  - Both requests high: the read is performed and the write is dropped.
- Misalignment check at acceptance:
  - Fault if half with addr[0]=1, or word/size 11 with addr[1:0]!=0.
  - On fault: go to DONE with misalign=1, no array access, rdata unchanged.
- Read path:
  - IDLE goes to RD_WAIT; counter loaded with READ_LAT-1 and decremented each cycle.
  - At count 0, transition to DONE and register rdata with the aligned, extended word.
  - ready is high in the cycle after READ_LAT+1 edges past acceptance.
- Write path:
  - IDLE goes to WR; the array is updated on the edge leaving WR, with only the selected byte lanes written.
  - Then DONE; ready appears 2 edges after acceptance.
- DONE:
  - ready=1 for exactly one cycle; misalign is meaningful only here and is 0 elsewhere.
  - Unconditional transition to IDLE.
- Request handling:
  - Requests seen while busy are ignored.
  - A request still high on return to IDLE is accepted again; the master must drop it on ready.
- Data hold:
  - rdata holds its value until the next successful read completes.
  - Writes and misaligned operations never change rdata.
- Reset mid-operation:
  - Reset asserted before the edge leaving WR means the array is not modified.
  - A pending read is discarded and rdata is 0.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (IDLE, RD_WAIT, WR, DONE).
- Sub-module data_mem_load_align, purely combinational: (word, addr[1:0], size, sign_ext) -> 32-bit aligned/extended value.
- The top level holds the FSM, counter, latches, byte-enable array write, and rdata register.

Test Plan:
1. Assert reset mid-cycle -> rdata=0, ready=0, busy=0, misalign=0 immediately, without waiting for a clock edge.
2. sw 0xDEADBEEF @0x10 -> ready 2 edges after accept. Then lw @0x10 (READ_LAT=2) -> ready 3 edges after accept, rdata=0xDEADBEEF, busy high throughout.
3. Loads after step 2:
   - lb @0x13 signed -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
   - lh @0x12 signed -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
4. sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF. sh 0x1234 @0x12, then lw @0x10 -> 0x123455EF.
5. Misalignment:
   - lh @0x11 -> ready 1 edge after accept, misalign=1, rdata unchanged.
   - sw 0xFFFFFFFF @0x12 -> misalign=1; a subsequent lw @0x10 returns the previous value.
6. Simultaneous mem_read and mem_write @0x10 -> read timing and data, no write. Then sw 0x12345678 @0x20 with reset asserted during WR -> lw @0x20 returns the prior contents.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states and the
// alignment rule applied when a request is accepted.
package data_mem_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        DONE
    } state_e;

    // Halves must be 2-byte aligned; words (including the 11 encoding) 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        logic fault;
        fault = 1'b0;
        if (size == SZ_HALF)
            fault = byte_off[0];
        else if (size[1])
            fault = (byte_off != 2'b00);
        return fault;
    endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Load alignment: picks the addressed byte/half lane out of a stored word and
// sign- or zero-extends it to 32 bits.
module data_mem_load_align
    import data_mem_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{byte_off, 3'b000} +: 8];
        lane_h = word[{byte_off[1], 4'b0000} +: 16];
        case (size_e'(size))
            SZ_BYTE: value = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: value = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with a request/ready handshake, configurable read
// wait states and byte/halfword lane handling on both loads and stores.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e              state, next_state;
    logic [2:0]          wait_cnt;
    logic [ADDR_W-1:0]   word_q;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                sign_q;
    logic [31:0]         wdata_q;
    logic                misalign_q;

    logic                accept;
    logic                fault;
    logic [31:0]         mem_word;
    logic [31:0]         load_value;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;

    logic [31:0]         mem [DEPTH];

    assign accept   = (state == IDLE) && (mem_read || mem_write);
    assign fault    = is_misaligned(size, addr[1:0]);
    assign mem_word = mem[word_q];

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (fault)
                        next_state = DONE;
                    else if (mem_read)
                        next_state = RD_WAIT;
                    else
                        next_state = WR;
                end
            end
            RD_WAIT: if (wait_cnt == 3'd0) next_state = DONE;
            WR:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ready    = (state == DONE);
    assign misalign = ready & misalign_q;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            word_q     <= '0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            wdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            rdata      <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                word_q     <= addr[ADDR_W+1:2];
                off_q      <= addr[1:0];
                size_q     <= size;
                sign_q     <= sign_ext;
                wdata_q    <= wdata;
                misalign_q <= fault;
                wait_cnt   <= 3'(READ_LAT - 1);
            end else if (state == RD_WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (state == RD_WAIT && wait_cnt == 3'd0)
                rdata <= load_value;
        end
    end

    data_mem_load_align u_load_align (
        .word     (mem_word),
        .byte_off (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .value    (load_value)
    );

    // Stores are right-justified: replicate the low lane across the word and
    // let the byte enables pick the target lanes.
    always_comb begin
        case (size_e'(size_q))
            SZ_BYTE: begin
                wr_be   = 4'b0001 << off_q;
                wr_data = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    // NOTE: the array has no reset; a reset during WR is safe because it forces
    // state out of WR before the edge that would commit the store.
    always_ff @(posedge clk) begin
        if (state == WR) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[word_q][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: a reference word array predicts each
// transaction's data, misalign flag and latency, queued at issue and checked on ready.
module tb_data_mem_unit;

    localparam int ADDR_W   = 8;
    localparam int READ_LAT = 2;
    localparam int BUDGET   = 20;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        misalign;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        misalign;
        int          latency;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [1 << ADDR_W];
    logic [31:0] ref_rdata;
    int          n_checks;
    int          n_fail;

    data_mem_unit #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .size      (size),
        .sign_ext  (sign_ext),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_fault(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return off[0];
        return off != 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) return (sg && b[7])  ? {24'hFFFFFF, b} : {24'h0, b};
        if (sz == 2'b01) return (sg && h[15]) ? {16'hFFFF, h}   : {16'h0, h};
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int idx;
        idx = int'(a[ADDR_W+1:2]);
        case (sz)
            2'b00: ref_mem[idx][8*a[1:0] +: 8] = wd[7:0];
            2'b01: ref_mem[idx][16*a[1] +: 16] = wd[15:0];
            default: ref_mem[idx] = wd;
        endcase
    endtask

    // Issue one request (called just after a rising edge), predict it, wait for ready, compare.
    task automatic do_op(input string name, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        exp_t e;
        int   edges;
        logic busy_ok;
        e.name = name;
        e.misalign = model_fault(sz, a[1:0]);
        if (e.misalign) begin
            e.latency = 1;
        end else if (rd) begin
            ref_rdata = model_load(ref_mem[int'(a[ADDR_W+1:2])], a[1:0], sz, sg);
            e.latency = READ_LAT + 1;
        end else begin
            model_store(a, sz, wd);
            e.latency = 2;
        end
        e.rdata = ref_rdata;
        sb_q.push_back(e);

        mem_read = rd; mem_write = wr; addr = a; size = sz; sign_ext = sg; wdata = wd;
        edges = 0;
        busy_ok = 1'b1;
        while (edges < BUDGET) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                addr = ~a; size = ~sz; sign_ext = ~sg; wdata = ~wd;
            end
            if (ready) break;
            if (!busy) busy_ok = 1'b0;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        e = sb_q.pop_front();

        n_checks++;
        if (!ready) begin
            n_fail++;
            $display("FAIL %s timeout: no ready within %0d edges", e.name, BUDGET);
            return;
        end
        n_checks++;
        if (edges !== e.latency) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected %0d", e.name, edges, e.latency);
        end
        n_checks++;
        if (misalign !== e.misalign) begin
            n_fail++;
            $display("FAIL %s misalign: got %b, expected %b", e.name, misalign, e.misalign);
        end
        n_checks++;
        if (rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h, expected %h", e.name, rdata, e.rdata);
        end
        n_checks++;
        if (!busy_ok || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: dropped while operation in flight", e.name);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse: ready=%b busy=%b misalign=%b, expected 0 0 0",
                     e.name, ready, busy, misalign);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (rdata !== 32'd0 || ready !== 1'b0 || busy !== 1'b0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdata=%h ready=%b busy=%b misalign=%b, expected all 0",
                     name, rdata, ready, busy, misalign);
        end
    endtask

    // Hold reset across one rising edge, release away from the edge, resync.
    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; size = 2'b10; sign_ext = 1'b0; wdata = '0;
        #3 reset = 1'b1;
        #1 check_reset_outputs("reset_async");
        ref_rdata = 32'd0;
        release_reset();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_word();
        do_op("sw_10", 1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        do_op("lw_10", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    endtask

    task automatic test_loads();
        do_op("lb_13",  1'b1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
        do_op("lbu_13", 1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        do_op("lh_12",  1'b1, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
        do_op("lhu_10", 1'b1, 1'b0, 32'h10, 2'b01, 1'b0, 32'h0);
        do_op("lw_wrap", 1'b1, 1'b0, 32'h0000_0410, 2'b11, 1'b0, 32'h0);
    endtask

    task automatic test_partial_stores();
        do_op("sb_11",    1'b0, 1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFF_FF55);
        do_op("lw_after_sb", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        do_op("sh_12",    1'b0, 1'b1, 32'h12, 2'b01, 1'b0, 32'hABCD_1234);
        do_op("lw_after_sh", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        do_op("lh_11_mis", 1'b1, 1'b0, 32'h11, 2'b01, 1'b1, 32'h0);
        do_op("sw_12_mis", 1'b0, 1'b1, 32'h12, 2'b10, 1'b0, 32'hFFFFFFFF);
        do_op("lw_after_mis", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    endtask

    task automatic test_rw_and_reset_abort();
        do_op("rw_both_10", 1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hAAAA_AAAA);
        do_op("lw_no_write", 1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        do_op("sw_20", 1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFE_F00D);

        mem_write = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_write = 1'b0;
        reset = 1'b1;
        #1 check_reset_outputs("reset_in_wr");
        ref_rdata = 32'd0;
        release_reset();
        do_op("lw_20_prior", 1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0);

        mem_read = 1'b1; addr = 32'h10; size = 2'b10;
        @(posedge clk); #1;
        mem_read = 1'b0;
        reset = 1'b1;
        #1 check_reset_outputs("reset_in_read");
        ref_rdata = 32'd0;
        release_reset();
        do_op("lb_10_after_abort", 1'b1, 1'b0, 32'h10, 2'b00, 1'b1, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_word();
        test_loads();
        test_partial_stores();
        test_misalign();
        test_rw_and_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
